mem_stage: RTL and testbench

- MEM stage of the five-stage Beta pipeline, between the ALU stage and the write-back stage.
- Registers the ALU-stage results and decodes LD/ST/LDR from the IR.
- Runs a req/ack transaction on the data-memory port and stalls the upstream pipeline while the access is outstanding.
- Presents pc/ir/y plus registered read data to write-back, and exports a bypass tap for operand forwarding.

---
 rtl/mem_stage.sv | 102 ++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Beta MEM stage: stage registers, LD/ST/LDR decode, data-memory req/ack, WB outputs and bypass tap (option: MEM_ALIGN_CHECK_EN).
// Latency: 1 cycle to write-back. A zero-wait access adds no cycles, and each memory wait cycle adds one stall cycle.
// Backpressure: mem_stall holds the stage and upstream stages until dmem_ack, and write-back receives NOP_IR bubbles meanwhile.
module mem_stage #(
  parameter logic [31:0] NOP_IR   = 32'h83FFF800,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_mem_next,
  input  logic [31:0] ir_mem_next,
  input  logic [31:0] y_mem_next,
  input  logic [31:0] st_mem_next,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rd,
  output logic        mem_stall,
  output logic [31:0] pc_wb_next,
  output logic [31:0] ir_wb_next,
  output logic [31:0] y_wb_next,
  output logic [31:0] mem_rd,
  output logic        byp_valid,
  output logic [4:0]  byp_addr,
  output logic [31:0] byp_data,
  output logic        byp_ld_pending,
  output logic        misalign
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_mem, ir_mem, y_mem, st_mem;
  logic        is_ld, is_st, is_ldr, is_mem, mis;

  assign is_ld  = (ir_mem[31:26] == 6'h18);
  assign is_st  = (ir_mem[31:26] == 6'h19);
  assign is_ldr = (ir_mem[31:26] == 6'h1F);
  assign is_mem = is_ld | is_st | is_ldr;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_mem & (y_mem[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (dmem_req && !dmem_ack) state_nxt = S_WAIT;
      S_WAIT:  if (dmem_ack) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    dmem_req  = is_mem & ~mis & ((state == S_RUN) | (state == S_WAIT));
    dmem_we   = is_st;
    dmem_addr = y_mem;
    dmem_wd   = st_mem;
    mem_stall = dmem_req & ~dmem_ack;
    misalign  = mis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mem <= RESET_PC;
      ir_mem <= NOP_IR;
      y_mem  <= 32'd0;
      st_mem <= 32'd0;
    end else if (!mem_stall) begin
      pc_mem <= pc_mem_next;
      ir_mem <= ir_mem_next;
      y_mem  <= y_mem_next;
      st_mem <= st_mem_next;
    end
  end

  // Gating with dmem_req drops any ack that arrives without an outstanding request.
  always_ff @(posedge clk) begin
    if (rst)                                mem_rd <= 32'd0;
    else if (dmem_req && dmem_ack && !dmem_we) mem_rd <= dmem_rd;
  end

  // A stalled instruction is shown to write-back only on its final (acked) cycle, so it commits once.
  assign pc_wb_next = pc_mem;
  assign ir_wb_next = (mem_stall | mis) ? NOP_IR : ir_mem;
  assign y_wb_next  = mem_stall ? 32'd0 : y_mem;

  assign byp_addr       = ir_mem[25:21];
  assign byp_data       = y_mem;
  assign byp_valid      = ~is_st & ~is_ld & ~is_ldr & (byp_addr != 5'd31);
  assign byp_ld_pending = (is_ld | is_ldr) & (byp_addr != 5'd31);

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector table plus hand-written multi-cycle sequences for mem_stage.
module tb_mem_stage;

  localparam logic [31:0] NOP   = 32'h83FFF800;
  localparam logic [31:0] ADD5  = 32'h80A00000;
  localparam logic [31:0] ADD31 = 32'h83E00000;
  localparam logic [31:0] ADD6  = 32'h80C00000;
  localparam logic [31:0] ADD7  = 32'h80E00000;
  localparam logic [31:0] LD3   = 32'h60600000;
  localparam logic [31:0] LD31  = 32'h63E00000;
  localparam logic [31:0] ST2   = 32'h64400000;
  localparam logic [31:0] LDR4  = 32'h7C800000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_mem_next = '0, ir_mem_next = '0, y_mem_next = '0, st_mem_next = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wd, dmem_rd = '0;
  logic        mem_stall, byp_valid, byp_ld_pending, misalign;
  logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, mem_rd, byp_data;
  logic [4:0]  byp_addr;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
    .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .dmem_ack(dmem_ack), .dmem_rd(dmem_rd), .mem_stall(mem_stall),
    .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next), .y_wb_next(y_wb_next),
    .mem_rd(mem_rd), .byp_valid(byp_valid), .byp_addr(byp_addr),
    .byp_data(byp_data), .byp_ld_pending(byp_ld_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, ir, y, st;
    logic        ack;
    logic [31:0] rd;
    logic        e_req, e_we, e_bv, e_lp;
    logic [4:0]  e_ba;
    logic [31:0] e_irwb, e_mem_rd;
  } vec_t;

  vec_t vt[9];

  initial begin
    //        pc      ir     y          st           ack  rd            req we bv lp ba  irwb   mem_rd (this cycle)
    vt[0] = '{32'h10, ADD5,  32'h7,     32'h0,       1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b0,5'd5,  ADD5,  32'h0};
    vt[1] = '{32'h14, ADD31, 32'h9,     32'h0,       1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,5'd31, ADD31, 32'h0};
    vt[2] = '{32'h18, LD3,   32'h100,   32'h0,       1'b1, 32'hDEADBEEF, 1'b1,1'b0,1'b0,1'b1,5'd3,  LD3,   32'h0};
    vt[3] = '{32'h1C, ADD5,  32'h7,     32'h0,       1'b0, 32'h0,        1'b0,1'b0,1'b1,1'b0,5'd5,  ADD5,  32'hDEADBEEF};
    vt[4] = '{32'h20, ST2,   32'h200,   32'hA5A5A5A5,1'b1, 32'h11111111, 1'b1,1'b1,1'b0,1'b0,5'd2,  ST2,   32'hDEADBEEF};
    vt[5] = '{32'h24, LDR4,  32'h300,   32'h0,       1'b1, 32'hCAFEF00D, 1'b1,1'b0,1'b0,1'b1,5'd4,  LDR4,  32'hDEADBEEF};
    vt[6] = '{32'h28, LD31,  32'h104,   32'h0,       1'b1, 32'h00001234, 1'b1,1'b0,1'b0,1'b0,5'd31, LD31,  32'hCAFEF00D};
    vt[7] = '{32'h2C, ADD6,  32'h55,    32'h0,       1'b1, 32'h00000BAD, 1'b0,1'b0,1'b1,1'b0,5'd6,  ADD6,  32'h00001234};
    vt[8] = '{32'h30, NOP,   32'h0,     32'h0,       1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,5'd31, NOP,   32'h00001234};

    // Reset with non-NOP values on the inputs: the stage must still come up as a bubble.
    ir_mem_next = ADD5; pc_mem_next = 32'h44; y_mem_next = 32'h9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ir_wb", ir_wb_next, NOP);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_mem_rd", mem_rd, 32'd0);
    chk("rst_pc_wb", pc_wb_next, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      pc_mem_next = vt[i].pc; ir_mem_next = vt[i].ir;
      y_mem_next = vt[i].y;   st_mem_next = vt[i].st;
      @(posedge clk);
      #1;
      dmem_ack = vt[i].ack; dmem_rd = vt[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d_stall", i), {31'd0, mem_stall}, 32'd0);
      chk($sformatf("v%0d_ir_wb", i), ir_wb_next, vt[i].e_irwb);
      chk($sformatf("v%0d_pc_wb", i), pc_wb_next, vt[i].pc);
      chk($sformatf("v%0d_y_wb", i), y_wb_next, vt[i].y);
      chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].y);
      chk($sformatf("v%0d_wd", i), dmem_wd, vt[i].st);
      chk($sformatf("v%0d_byp_data", i), byp_data, vt[i].y);
      chk($sformatf("v%0d_byp_addr", i), {27'd0, byp_addr}, {27'd0, vt[i].e_ba});
      chk($sformatf("v%0d_byp_valid", i), {31'd0, byp_valid}, {31'd0, vt[i].e_bv});
      chk($sformatf("v%0d_ld_pend", i), {31'd0, byp_ld_pending}, {31'd0, vt[i].e_lp});
      chk($sformatf("v%0d_mem_rd", i), mem_rd, vt[i].e_mem_rd);
      if (vt[i].e_req) chk($sformatf("v%0d_we", i), {31'd0, dmem_we}, {31'd0, vt[i].e_we});
    end

    // Three-wait store: acked on its fourth cycle.
    @(negedge clk);
    dmem_ack = 1'b0;
    pc_mem_next = 32'h80; ir_mem_next = ST2; y_mem_next = 32'h200; st_mem_next = 32'h12345678;
    @(posedge clk);
    #1;
    pc_mem_next = 32'h84; ir_mem_next = ADD7; y_mem_next = 32'h77; st_mem_next = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        @(posedge clk);
        #1;
        dmem_ack = 1'b1; dmem_rd = 32'hFFFF0000;
      end else if (c > 0) begin
        @(posedge clk);
      end
      @(negedge clk);
      chk($sformatf("st_c%0d_req", c), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("st_c%0d_we", c), {31'd0, dmem_we}, 32'd1);
      chk($sformatf("st_c%0d_addr", c), dmem_addr, 32'h200);
      chk($sformatf("st_c%0d_wd", c), dmem_wd, 32'h12345678);
      chk($sformatf("st_c%0d_stall", c), {31'd0, mem_stall}, (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("st_c%0d_ir_wb", c), ir_wb_next, (c < 3) ? NOP : ST2);
      chk($sformatf("st_c%0d_y_wb", c), y_wb_next, (c < 3) ? 32'h0 : 32'h200);
      chk($sformatf("st_c%0d_pc_wb", c), pc_wb_next, 32'h80);
    end
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("st_after_ir_wb", ir_wb_next, ADD7);
    chk("st_after_mem_rd", mem_rd, 32'h00001234);

    // Reset while an LD is waiting on memory.
    @(negedge clk);
    pc_mem_next = 32'h90; ir_mem_next = LD3; y_mem_next = 32'h100;
    @(posedge clk);
    #1;
    ir_mem_next = NOP; y_mem_next = 32'h0;
    @(negedge clk);
    chk("rw_stall_before", {31'd0, mem_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_ir_wb", ir_wb_next, NOP);

    // Misaligned LD.
    @(negedge clk);
    pc_mem_next = 32'hA0; ir_mem_next = LD3; y_mem_next = 32'h102;
    @(posedge clk);
    #1;
    dmem_ack = 1'b1; dmem_rd = 32'h0BADF00D;
    ir_mem_next = NOP; y_mem_next = 32'h0;
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_ir_wb", ir_wb_next, NOP);
`else
    chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_req", {31'd0, dmem_req}, 32'd1);
    chk("mis_addr", dmem_addr, 32'h102);
    chk("mis_ir_wb", ir_wb_next, LD3);
`endif
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_mem_rd", mem_rd, 32'h00000000);
`else
    chk("mis_mem_rd", mem_rd, 32'h0BADF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
